// File: rtl/alu_chain_ctrl_if.sv
// Handshake and bus bundle for alu_chain_ctrl.
// Groups the command, ALU and result signals; slave = controller side.
interface alu_chain_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [1:0]  cmd_len;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_cin;
  logic [7:0]  alu_opA;
  logic [7:0]  alu_opB;
  logic [3:0]  alu_opcode;
  logic        alu_cin;
  logic [7:0]  alu_outQ;
  logic        alu_cout;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_cout;
  logic        res_zero;

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_a, cmd_b, cmd_cin,
    output cmd_ready,
    output alu_opA, alu_opB, alu_opcode, alu_cin,
    input  alu_outQ, alu_cout,
    output res_valid, res_data, res_cout, res_zero,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_a, cmd_b, cmd_cin,
    input  cmd_ready,
    input  alu_opA, alu_opB, alu_opcode, alu_cin,
    output alu_outQ, alu_cout,
    input  res_valid, res_data, res_cout, res_zero,
    output res_ready
  );
endinterface

// File: rtl/alu_chain_ctrl.sv
// Multi-byte sequencer in front of an 8-bit registered ALU.
// Ports: clk, rst (async high), bus (cmd in, alu out/in, res out).
module alu_chain_ctrl #(
  parameter int ALU_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  alu_chain_ctrl_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_LSH = 4'd2;
  localparam logic [3:0] OP_RSH = 4'd3;
  localparam logic [3:0] OP_CMP = 4'd5;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_op;
  logic [1:0]  r_len, r_k, r_cnt;
  logic [31:0] r_a, r_b, r_res;
  logic        r_cin, r_c, r_first, r_cout, r_zero;
  logic [7:0]  r_opA, r_opB;
  logic [3:0]  r_opc;
  logic        r_acin;

  logic [7:0]  w_opA, w_opB;
  logic [3:0]  w_opc;
  logic        w_acin;
  logic [4:0]  w_sh;
  logic [7:0]  w_ak, w_bk;
  logic        w_msb_first, w_last_wait, w_last_byte;
  logic [31:0] w_res_next;
  logic        w_fcout;

  assign w_sh = {r_k, 3'b000};
  assign w_ak = r_a[w_sh +: 8];
  assign w_bk = r_b[w_sh +: 8];

  assign w_msb_first = (r_op == OP_RSH) || (r_op == OP_CMP);
  assign w_last_wait = (r_state == WAIT) &&
                       (r_cnt == 2'(ALU_LAT - 1));

  // CMP stops early on the first byte that is not "equal".
  always_comb begin
    w_last_byte = (r_k == r_len);
    if (r_op == OP_CMP)
      w_last_byte = (r_k == 2'd0) || (bus.alu_outQ != 8'h01);
    else if (w_msb_first)
      w_last_byte = (r_k == 2'd0);
  end

  assign w_res_next = (r_op == OP_CMP) ? {24'h0, bus.alu_outQ}
                    : r_res | ({24'h0, bus.alu_outQ} << w_sh);

  always_comb begin
    w_fcout = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: w_fcout = bus.alu_cout;
      OP_LSH:         w_fcout = r_a[{r_len, 3'b111}];
      OP_RSH:         w_fcout = r_a[0];
      default:        w_fcout = 1'b0;
    endcase
  end

  // Shift chaining reads the neighbour byte straight from operand A.
  always_comb begin
    w_opA  = w_ak;
    w_opB  = w_bk;
    w_opc  = r_op;
    w_acin = 1'b0;
    case (r_op)
      OP_ADD: w_acin = r_first ? r_cin : r_c;
      OP_SUB: begin
        w_opB  = ~w_bk;
        w_opc  = OP_ADD;
        w_acin = r_first ? 1'b1 : r_c;
      end
      OP_LSH: begin
        w_opB  = w_ak;
        w_acin = r_first ? r_cin : r_a[{r_k - 2'd1, 3'b111}];
      end
      OP_RSH: begin
        w_opB  = w_ak;
        w_acin = r_first ? r_cin : r_a[{r_k + 2'd1, 3'b000}];
      end
      default: ;
    endcase
  end

  assign bus.alu_opA    = (r_state == ISSUE) ? w_opA  : r_opA;
  assign bus.alu_opB    = (r_state == ISSUE) ? w_opB  : r_opB;
  assign bus.alu_opcode = (r_state == ISSUE) ? w_opc  : r_opc;
  assign bus.alu_cin    = (r_state == ISSUE) ? w_acin : r_acin;

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.res_valid = (r_state == DONE);
  assign bus.res_data  = r_res;
  assign bus.res_cout  = r_cout;
  assign bus.res_zero  = r_zero;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (bus.cmd_valid) w_next = ISSUE;
      ISSUE: w_next = WAIT;
      WAIT:  if (w_last_wait) w_next = w_last_byte ? DONE : ISSUE;
      DONE:  if (bus.res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_len   <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cin   <= 1'b0;
      r_c     <= 1'b0;
      r_first <= 1'b0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
      r_opA   <= '0;
      r_opB   <= '0;
      r_opc   <= '0;
      r_acin  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (bus.cmd_valid) begin
          r_op    <= bus.cmd_op;
          r_len   <= bus.cmd_len;
          r_a     <= bus.cmd_a;
          r_b     <= bus.cmd_b;
          r_cin   <= bus.cmd_cin;
          r_k     <= (bus.cmd_op == OP_RSH || bus.cmd_op == OP_CMP)
                     ? bus.cmd_len : 2'd0;
          r_res   <= '0;
          r_first <= 1'b1;
          r_cout  <= 1'b0;
          r_zero  <= 1'b0;
        end
        ISSUE: begin
          r_opA  <= w_opA;
          r_opB  <= w_opB;
          r_opc  <= w_opc;
          r_acin <= w_acin;
          r_cnt  <= '0;
        end
        WAIT: if (!w_last_wait) begin
          r_cnt <= r_cnt + 2'd1;
        end else begin
          r_first <= 1'b0;
          r_c     <= bus.alu_cout;
          r_res   <= w_res_next;
          if (w_last_byte) begin
            r_cout <= w_fcout;
            r_zero <= (w_res_next == 32'h0);
          end else begin
            r_k <= w_msb_first ? r_k - 2'd1 : r_k + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_chain_ctrl.sv
// Directed bench for alu_chain_ctrl with a behavioural 8-bit ALU.
// Checks reset, arithmetic, shifts, compare, backpressure, mid-op reset.
module tb_alu_chain_ctrl;
  localparam int ALU_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] opa_log [16];

  always #5 clk = ~clk;

  alu_chain_ctrl_if bus ();

  alu_chain_ctrl #(.ALU_LAT(ALU_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [8:0] alu_f(
    input logic [7:0] a, input logic [7:0] b,
    input logic [3:0] op, input logic c);
    logic [8:0] r;
    case (op)
      4'd0: r = {1'b0, a} + {1'b0, b} + {8'h0, c};
      4'd1: r = {1'b0, a} + {1'b0, ~b} + 9'd1;
      4'd2: r = {a[7], a[6:0], c};
      4'd3: r = {a[0], c, a[7:1]};
      4'd4: r = {1'b0, a ^ b};
      4'd5: r = (a == b) ? 9'h001 : (a > b) ? 9'h002 : 9'h004;
      4'd6: r = {1'b0, a & b};
      4'd7: r = {1'b0, ~(a & b)};
      4'd8: r = {1'b0, a | b};
      4'd9: r = {1'b0, ~(a | b)};
      default: r = 9'h0;
    endcase
    return r;
  endfunction

  logic [8:0] pipe [ALU_LAT];
  always @(posedge clk) begin
    pipe[0] <= alu_f(bus.alu_opA, bus.alu_opB,
                     bus.alu_opcode, bus.alu_cin);
    for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.alu_outQ = pipe[ALU_LAT-1][7:0];
  assign bus.alu_cout = pipe[ALU_LAT-1][8];

  task automatic do_cmd(
    input logic [3:0] op, input logic [1:0] len,
    input logic [31:0] a, input logic [31:0] b,
    input logic cin, input bit ack,
    output logic [31:0] d, output logic c,
    output logic z, output int lat);
    int n;
    @(negedge clk);
    bus.cmd_op = op;
    bus.cmd_len = len;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_cin = cin;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout op=%0d cmd_ready=%b want 1",
               op, bus.cmd_ready);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = 32'hDEADBEEF;
    bus.cmd_b = 32'hCAFEF00D;
    opa_log[0] = bus.alu_opA;
    lat = 0;
    while (!bus.res_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat < 16) opa_log[lat] = bus.alu_opA;
    end
    checks++;
    if (bus.res_valid !== 1'b1) begin
      errors++;
      $display("FAIL result_timeout op=%0d res_valid=%b want 1",
               op, bus.res_valid);
    end
    d = bus.res_data;
    c = bus.res_cout;
    z = bus.res_zero;
    if (ack) begin
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.cmd_ready, bus.res_valid, bus.res_cout, bus.res_zero}
        !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=1000",
        {bus.cmd_ready, bus.res_valid, bus.res_cout, bus.res_zero});
    end
    checks++;
    if (bus.res_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", bus.res_data);
    end
    checks++;
    if ({bus.alu_opA, bus.alu_opB, bus.alu_opcode, bus.alu_cin}
        !== 21'h0) begin
      errors++;
      $display("FAIL reset_alu got=%h want=0",
        {bus.alu_opA, bus.alu_opB, bus.alu_opcode, bus.alu_cin});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    logic [31:0] d; logic c, z; int lat;
    do_cmd(4'd0, 2'd1, 32'h00FF, 32'h0001, 1'b0, 1'b1, d, c, z, lat);
    checks++;
    if ({d, c, z} !== {32'h0100, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add data=%h c=%b z=%b want 00000100 0 0", d, c, z);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL add_latency got=%0d want=4", lat);
    end
  endtask

  task automatic test_sub;
    logic [31:0] d; logic c, z; int lat;
    do_cmd(4'd1, 2'd3, 32'h0, 32'h1, 1'b1, 1'b1, d, c, z, lat);
    checks++;
    if ({d, c, z} !== {32'hFFFFFFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow data=%h c=%b z=%b want ffffffff 0 0",
               d, c, z);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL sub_latency got=%0d want=8", lat);
    end
    do_cmd(4'd1, 2'd1, 32'h1234, 32'h1234, 1'b0, 1'b1, d, c, z, lat);
    checks++;
    if ({d, c, z} !== {32'h0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_equal data=%h c=%b z=%b want 00000000 1 1",
               d, c, z);
    end
  endtask

  task automatic test_shift;
    logic [31:0] d; logic c, z; int lat;
    do_cmd(4'd2, 2'd1, 32'h8001, 32'h0, 1'b1, 1'b1, d, c, z, lat);
    checks++;
    if ({d, c} !== {32'h0003, 1'b1}) begin
      errors++;
      $display("FAIL lshift data=%h c=%b want 00000003 1", d, c);
    end
    do_cmd(4'd3, 2'd1, 32'h8001, 32'h0, 1'b0, 1'b1, d, c, z, lat);
    checks++;
    if ({d, c} !== {32'h4000, 1'b1}) begin
      errors++;
      $display("FAIL rshift data=%h c=%b want 00004000 1", d, c);
    end
    checks++;
    if ({opa_log[0], opa_log[2]} !== 16'h8001) begin
      errors++;
      $display("FAIL rshift_order got=%h want=8001",
               {opa_log[0], opa_log[2]});
    end
  endtask

  task automatic test_cmp;
    logic [31:0] d; logic c, z; int lat;
    do_cmd(4'd5, 2'd3, 32'h12345678, 32'h12340000, 1'b1, 1'b1,
           d, c, z, lat);
    checks++;
    if ({d, c, lat} !== {32'h02, 1'b0, 32'd6}) begin
      errors++;
      $display("FAIL cmp_gt data=%h c=%b lat=%0d want 00000002 0 6",
               d, c, lat);
    end
    do_cmd(4'd5, 2'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b1,
           d, c, z, lat);
    checks++;
    if ({d, c, lat} !== {32'h01, 1'b0, 32'd8}) begin
      errors++;
      $display("FAIL cmp_eq data=%h c=%b lat=%0d want 00000001 0 8",
               d, c, lat);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d; logic c, z; int lat;
    bit bad;
    do_cmd(4'd0, 2'd0, 32'h5, 32'h3, 1'b0, 1'b0, d, c, z, lat);
    bus.cmd_op = 4'd4;
    bus.cmd_len = 2'd0;
    bus.cmd_a = 32'hAA;
    bus.cmd_b = 32'h0F;
    bus.cmd_cin = 1'b0;
    bus.cmd_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h8 ||
          bus.cmd_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stall valid=%b data=%h rdy=%b want 1 00000008 0",
               bus.res_valid, bus.res_data, bus.cmd_ready);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    checks++;
    if ({bus.cmd_ready, bus.res_valid} !== 2'b10) begin
      errors++;
      $display("FAIL after_handshake rdy/valid=%b want 10",
               {bus.cmd_ready, bus.res_valid});
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.res_valid, bus.res_data} !== {1'b1, 32'hA5}) begin
      errors++;
      $display("FAIL next_cmd valid=%b data=%h want 1 000000a5",
               bus.res_valid, bus.res_data);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic c, z; int lat;
    @(negedge clk);
    bus.cmd_op = 4'd0;
    bus.cmd_len = 2'd3;
    bus.cmd_a = 32'h11223344;
    bus.cmd_b = 32'h01010101;
    bus.cmd_cin = 1'b0;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({bus.alu_opA, bus.alu_opB} !== 16'h2201) begin
      errors++;
      $display("FAIL mid_byte2 got=%h want=2201",
               {bus.alu_opA, bus.alu_opB});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.res_valid, bus.alu_opA, bus.alu_opB,
         bus.alu_opcode, bus.alu_cin, bus.res_data} !==
        {2'b10, 21'h0, 32'h0}) begin
      errors++;
      $display("FAIL mid_reset rdy=%b val=%b alu=%h data=%h want 1 0 0 0",
        bus.cmd_ready, bus.res_valid,
        {bus.alu_opA, bus.alu_opB, bus.alu_opcode, bus.alu_cin},
        bus.res_data);
    end
    @(negedge clk);
    rst = 1'b0;
    do_cmd(4'd6, 2'd0, 32'hF0, 32'h3C, 1'b1, 1'b1, d, c, z, lat);
    checks++;
    if ({d, c, z, lat} !== {32'h30, 1'b0, 1'b0, 32'd2}) begin
      errors++;
      $display("FAIL and_after_reset data=%h c=%b z=%b lat=%0d want 30 0 0 2",
               d, c, z, lat);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_len = '0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_cin = 1'b0;
    bus.res_ready = 1'b0;
    test_reset;
    test_add;
    test_sub;
    test_shift;
    test_cmp;
    test_backpressure;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_chain_ctrl.md
Name: alu_chain_ctrl

Overview:
- Multi-byte operation sequencer placed directly upstream of the 8-bit registered ALU.
- Accepts one command of up to 32 bits over a valid/ready handshake.
- Splits the command into byte operations and issues them to the ALU one byte at a time.
- Chains carry and shift bits between bytes, captures each ALU result byte, and returns the assembled result with carry and zero flags over a valid/ready handshake.

Parameters:
- ALU_LAT, 1: number of clk edges between driving alu_* inputs and alu_outQ/alu_cout being valid. Legal range 1..3.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  4  ALU opcode: 0 ADD, 1 SUB, 2 LSHIFT, 3 RSHIFT, 4 XOR, 5 CMP, 6 AND, 7 NAND, 8 OR, 9 NOR.
- cmd_len  in  2  operand length in bytes minus 1.
- cmd_a  in  32  operand A.
- cmd_b  in  32  operand B.
- cmd_cin  in  1  carry/shift-in bit.
- alu_opA  out  8  ALU operand A.
- alu_opB  out  8  ALU operand B.
- alu_opcode  out  4  ALU opcode.
- alu_cin  out  1  ALU carry-in.
- alu_outQ  in  8  ALU result.
- alu_cout  in  1  ALU carry-out.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts the result.
- res_data  out  32  result.
- res_cout  out  1  final carry/shift-out bit.
- res_zero  out  1  result equals zero.

Behaviour:
- Reset (async, any state): state=IDLE. cmd_ready=1 (IDLE). res_valid=0, res_data=0, res_cout=0, res_zero=0. All alu_* outputs = 0. Any partial operation is discarded.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch the command, byte index k=first byte, go to ISSUE.
  - ISSUE: one cycle. Drive alu_* for byte k, go to WAIT.
  - WAIT: counts ALU_LAT-1 extra cycles. At the last WAIT cycle, capture alu_outQ/alu_cout for byte k, then either advance k and go to ISSUE, or go to DONE.
  - DONE: res_valid=1; outputs held stable until res_ready=1, then go to IDLE.
- cmd_ready is 1 only in IDLE. No command overlap.
- Cycles per byte = 1+ALU_LAT. For N bytes processed, res_valid rises N*(1+ALU_LAT) cycles after the accept edge (ALU_LAT=1, N=2: 4 cycles). A new command can be accepted the cycle after res_valid&&res_ready.
- alu_* values hold between ISSUE cycles.
- ADD: LSB byte first. opA=a[k], opB=b[k], opcode 0. cin = cmd_cin for byte 0, otherwise the captured alu_cout of byte k-1. res_cout = last alu_cout.
- SUB: issued as opcode ADD with opB=~b[k]. cin=1 for byte 0, then chained. cmd_cin is ignored. res_cout = final carry (1 = no borrow).
- LSHIFT: LSB byte first. opA=opB=a[k]. cin = cmd_cin for byte 0, else a[k-1] bit7. res_cout = bit7 of the top byte of a, computed by this block.
- RSHIFT: MSB byte first. opA=opB=a[k]. cin = cmd_cin for the top byte, else a[k+1] bit0. res_cout = a bit0.
- Bitwise ops (4, 6-9): LSB byte first, cin=0, res_cout=0.
- CMP: MSB byte first. Stop at the first byte with an ALU code != 0x01, or after byte 0. res_data = {24'h0, last code}, res_cout=0. Fewer bytes processed means shorter latency.
- Opcodes 0xA-0xF: issued as-is LSB-first, cin=0; result is whatever the ALU returns (0).
- res_data bytes above cmd_len are 0. res_zero = (res_data == 0).
- cmd_* inputs are sampled only at accept; later changes have no effect.

Test Plan:
- ADD, len=1, A=0x00FF, B=0x0001, cin=0 -> res_data=0x0100, res_cout=0, res_zero=0; res_valid exactly 4 cycles after accept (ALU_LAT=1).
- SUB, len=3, A=0x00000000, B=0x00000001 -> res_data=0xFFFFFFFF, res_cout=0. SUB with A=B=0x1234 (len=1) -> 0x0000, res_cout=1, res_zero=1.
- LSHIFT, len=1, A=0x8001, cin=1 -> 0x0003, res_cout=1. RSHIFT, len=1, A=0x8001, cin=0 -> 0x4000, res_cout=1; check the MSB-first issue order on alu_opA.
- CMP, len=3, A=0x12345678, B=0x12340000 -> res_data=0x02 after 3 bytes (6 cycles). A=B -> 0x01 after 8 cycles.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid and res_data stable, cmd_ready=0; next command is accepted only after the result handshake.
- Reset asserted during the WAIT of byte 2 of a 4-byte ADD -> immediate IDLE, res_valid=0, alu_*=0; a following 1-byte AND 0xF0&0x3C returns 0x30.
